// File: rtl/rv_div_seq.sv
// rv_div_seq: iterative RV32M DIV/DIVU/REM/REMU sequencer for the execute stage.
// Radix-2 restoring shift-subtract over XLEN cycles, then sign correction and
// special-case override. All outputs are registered.
// Optional feature macro: RV_DIV_EARLY_OUT_EN (divide-by-zero and signed
// overflow requests bypass CALC/FIX and complete one cycle after acceptance).
module rv_div_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned     CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   dividend_q, dividend_d;
    logic              is_signed_q, is_signed_d;
    logic              is_rem_q, is_rem_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic [XLEN-1:0]   result_d;

    logic              accept_c;
    logic              signed_in_c;
    logic [XLEN:0]     shift_c;
    logic [XLEN:0]     trial_c;
    logic              fix_dvz_c;
    logic              fix_ovf_c;

    // Architectural result for divide-by-zero / signed-overflow cases
    function automatic logic [XLEN-1:0] special_result(
        input logic            is_rem,
        input logic            dvz,
        input logic [XLEN-1:0] dividend
    );
        if (is_rem) begin
            return dvz ? dividend : '0;
        end
        return dvz ? ONES : INT_MIN;
    endfunction

    // Request qualification and one restoring-division step
    assign accept_c    = start_i && funct3_i[2] && !flush_i;
    assign signed_in_c = ~funct3_i[0];
    assign shift_c     = {rem_q, quo_q[XLEN-1]};
    assign trial_c     = shift_c - {1'b0, dvs_q};

    // Special cases seen from the latched magnitudes: |rs2|==1 with a
    // non-negative quotient sign means rs2 was -1
    assign fix_dvz_c = (dvs_q == '0);
    assign fix_ovf_c = is_signed_q && !q_neg_q && (dividend_q == INT_MIN)
                       && (dvs_q == XLEN'(1));

`ifdef RV_DIV_EARLY_OUT_EN
    logic early_c;
    // Requests whose result is known without iterating
    assign early_c = (rs2_i == '0)
                     || (signed_in_c && (rs1_i == INT_MIN) && (rs2_i == ONES));
`endif

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dividend_d  = dividend_q;
        is_signed_d = is_signed_q;
        is_rem_d    = is_rem_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        result_d    = result_o;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    is_signed_d = signed_in_c;
                    is_rem_d    = funct3_i[1];
                    quo_d       = (signed_in_c && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
                    dvs_d       = (signed_in_c && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
                    dividend_d  = rs1_i;
                    q_neg_d     = signed_in_c && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                    r_neg_d     = signed_in_c && rs1_i[XLEN-1];
                    cnt_d       = CNT_W'(XLEN - 1);
                    rem_d       = '0;
                    state_d     = S_CALC;
`ifdef RV_DIV_EARLY_OUT_EN
                    if (early_c) begin
                        result_d = special_result(funct3_i[1], (rs2_i == '0), rs1_i);
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (trial_c[XLEN]) begin
                    rem_d = shift_c[XLEN-1:0];
                end else begin
                    rem_d = trial_c[XLEN-1:0];
                end
                quo_d = {quo_q[XLEN-2:0], ~trial_c[XLEN]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (fix_dvz_c || fix_ovf_c) begin
                    result_d = special_result(is_rem_q, fix_dvz_c, dividend_q);
                end else if (is_rem_q) begin
                    result_d = r_neg_q ? -rem_q : rem_q;
                end else begin
                    result_d = q_neg_q ? -quo_q : quo_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: back to idle with the previous result kept
        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_o;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, iteration and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dividend_q  <= '0;
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            result_o    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dividend_q  <= dividend_d;
            is_signed_q <= is_signed_d;
            is_rem_q    <= is_rem_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            busy_o      <= (state_d != S_IDLE);
            done_o      <= (state_d == S_DONE);
            result_o    <= result_d;
        end
    end

endmodule

// File: doc/rv_div_seq.md
# rv_div_seq

Iterative RV32M divide sequencer for the execute stage. It accepts one DIV/DIVU/REM/REMU request at a time, runs a radix-2 restoring shift-subtract loop over 32 cycles and applies sign correction. It returns the architecturally defined result with a one-cycle done strobe. The pipeline holds the execute stage while `busy_o` is high; the single-cycle ALU continues to handle all non-M operations.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `start_i` input 1: request strobe; sampled only in IDLE.
- `funct3_i` input 3: operation select; 100 DIV, 101 DIVU, 110 REM, 111 REMU. funct3[2]=0 is treated as no-op: request ignored.
- `rs1_i` input XLEN: dividend; sampled with `start_i`.
- `rs2_i` input XLEN: divisor; sampled with `start_i`.
- `flush_i` input 1: abort the current operation (pipeline flush or trap).
- `busy_o` output 1: high whenever state != IDLE.
- `done_o` output 1: single-cycle strobe; `result_o` is valid in this cycle.
- `result_o` output XLEN: registered quotient or remainder; holds its value until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE.** On `start_i`=1 with valid funct3 and `flush_i`=0:
  - latch is_signed = ~funct3[0] and is_rem = funct3[1];
  - latch |rs1| and |rs2| (absolute values for signed ops, raw values for unsigned ops);
  - latch quotient sign q_neg = rs1[31]^rs2[31] and remainder sign r_neg = rs1[31], both for signed ops only;
  - set cnt=31 and partial remainder=0, then go to CALC.
- **CALC.** Each cycle, per iteration:
  - shift {rem, dvd} left by 1;
  - form trial = rem − divisor as a 33-bit subtraction;
  - if trial is non-negative, set rem = trial[31:0] and shift in quotient bit 1; otherwise keep rem and shift in 0;
  - decrement cnt; at cnt=0 go to FIX.
- **FIX.** Select the quotient, negated if q_neg, or the remainder, negated if r_neg. Apply the special cases below, then register the value into `result_o` and go to DONE.
- **DONE.** `done_o`=1 for this one cycle, then go to IDLE.
- Special cases are resolved in FIX and override the loop result:
  - divisor=0: DIV and DIVU return 0xFFFFFFFF; REM and REMU return the dividend unchanged.
  - signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- All arithmetic is two's complement, modulo 2^32. Negating 0x80000000 yields 0x80000000; that is correct for the unsigned magnitude path.
- **Flush.** `flush_i`=1 in any state forces IDLE at the next edge. No `done_o` is produced and `result_o` is unchanged.
- **Simultaneous events:**
  - `flush_i` and `start_i` in the same IDLE cycle: flush wins and the request is dropped.
  - `start_i` while busy: ignored, with no queueing.
  - `start_i` in the DONE cycle: ignored. The requester must see `busy_o`=0 before issuing.
- **Reset.** `rst_i` in any state, including mid-CALC, gives: state IDLE, cnt=0, `busy_o`=0, `done_o`=0, `result_o`=0, and all internal operand registers 0.

## Timing
- Acceptance edge N: `busy_o` rises in cycle N+1.
- CALC occupies edges N+1 … N+32. FIX occupies edge N+33.
- `done_o`=1 and `result_o` are valid in the cycle following edge N+33; `busy_o` is still 1 in that cycle.
- `busy_o` falls after edge N+34. A new request can be accepted at edge N+35 at the earliest.
- Fixed latency is 34 cycles from the acceptance cycle to `done_o`. It is independent of operand values unless the configuration macro below is defined.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- `RV_DIV_EARLY_OUT_EN`:
  - **Defined.** In IDLE, an accepted request with divisor=0, or with signed overflow, skips CALC and FIX. The special-case result is registered at acceptance edge N and the state goes directly to DONE. `done_o` is asserted in cycle N+1, a latency of 1, and `busy_o` is high only in that cycle.
  - **Undefined.** The special cases take the full 34-cycle path and produce the same result values.

## Test plan
- **DIVU.** rs1=100, rs2=7 → `result_o`=14. `done_o` is exactly 34 cycles after acceptance and high for 1 cycle.
- **REM and DIV with negative dividend.** REM rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFF (−1). DIV with the same operands → 0xFFFFFFFD (−3).
- **Divide by zero.** DIV rs1=5, rs2=0 → 0xFFFFFFFF. REMU rs1=0x1234, rs2=0 → 0x1234. Latency is 34 without the macro and 1 with `RV_DIV_EARLY_OUT_EN`.
- **Signed overflow.** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- **Flush mid-operation.** Start DIVU 100/7, then `flush_i` at cycle 10 → `busy_o`=0 next cycle, no `done_o`, `result_o` keeps its previous value. A following DIVU 9/3 → 3.
- **Reset and busy behaviour.**
  - `rst_i` at cycle 20 of an operation → all outputs 0 next cycle.
  - `start_i` held high during busy → exactly one completion per IDLE acceptance.
  - `start_i` together with `flush_i` in IDLE → no acceptance.
